if_mem_responder: RTL
=====================

Name: if_mem_responder

Overview:
- Responder end of the instruction-fetch interface.
- Accepts the fetch address and chip-enable from the PC stage and reads four bytes over the shared byte-wide RAM port.
- Assembles a little-endian 32-bit instruction and presents it to IF/ID.
- Raises a stall request while a fetch is in flight; a branch flushes the fetch.
- Holds a one-entry last-fetch buffer so that a repeated address (PC held by a stall) is served without memory traffic.

Parameters:
- ADDR_W, 32, instruction/memory address width
- INST_W, 32, instruction width; fixed at 4 bytes

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_W  fetch address from the PC stage
- ce_i  in  1  fetch enable; 0 = no request
- branch_flag_i  in  1  flush; aborts any in-flight fetch
- mem_gnt_i  in  1  RAM port granted to instruction side this cycle
- mem_addr_o  out  ADDR_W  byte address to RAM
- mem_rd_o  out  1  RAM read strobe
- mem_din_i  in  8  RAM read data; valid the cycle after a granted read
- inst_o  out  INST_W  assembled instruction
- inst_addr_o  out  ADDR_W  address of inst_o
- inst_valid_o  out  1  one-cycle pulse: inst_o/inst_addr_o valid
- stallreq_o  out  1  request pipeline stall (drives stall[0])

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, byte counters 0, buffer valid bit cleared.
- FSM states: IDLE, RD, LAST, DONE.
- IDLE, ce_i=1, branch_flag_i=0:
  - If buf_valid and pc_i==buf_addr: next cycle inst_valid_o=1, inst_o=buf_data, stallreq_o stays 0. Latency 1, no RAM access.
  - Otherwise latch req_addr=pc_i, issue_idx=0, go RD. stallreq_o=1 combinationally in the same cycle.
- RD: mem_rd_o=mem_gnt_i, mem_addr_o=req_addr+issue_idx.
  - issue_idx increments only on a cycle where mem_gnt_i=1.
  - Byte returned on mem_din_i the cycle after each granted read goes to byte lane rx_idx (rx_idx=0 is bits 7:0); rx_idx then increments.
  - Go LAST after issue_idx=3 is granted.
- LAST: mem_rd_o=0; capture byte 3; go DONE.
- DONE:
  - inst_valid_o=1 for exactly one cycle; inst_o=assembled word, inst_addr_o=req_addr.
  - Load buffer (buf_addr, buf_data, buf_valid=1); stallreq_o=0; go IDLE.
- Best case (grant always 1): accept T; reads at T+1..T+4; DONE at T+6 with inst_valid_o high. stallreq_o high T..T+5.
- Address arithmetic: req_addr+idx is modulo 2^ADDR_W. Fetch at 0xFFFFFFFE wraps to 0x0, 0x1; no alignment check.
- mem_gnt_i=0 in RD: no read is issued and the counter holds. A byte already in flight is still captured the next cycle, because read latency is fixed.
- branch_flag_i=1 in any state:
  - Next state IDLE; counters cleared; inst_valid_o=0 that cycle and next; stallreq_o=0 next cycle.
  - The in-flight byte is discarded; rx is not written after the flush.
  - The buffer is unaffected.
  - Flush in DONE suppresses the valid pulse and the buffer load.
- ce_i=0 in IDLE: no request. ce_i dropping during a fetch is ignored; only branch_flag_i aborts.
- inst_o, inst_addr_o hold their last values between pulses.

Decomposition:
- Shared defines package gains:
  - RAM byte-bus width (8)
  - FSM state encodings
  - InstValid/InstInvalid and StallReq/NoStallReq constants
- Reuse existing RstEnable-style defines, plus a new active-low RstN constant.
- One natural sub-module, `if_byte_assembler`: byte-lane write enable and the 32-bit shift/merge register.

Test Plan:
1. Grant tied 1; pc_i=0x100; RAM[0x100..0x103]=13,05,10,00 -> DONE cycle has inst_o=0x00100513, inst_addr_o=0x100, inst_valid_o one pulse at T+6; stallreq_o high T..T+5.
2. Same pc_i=0x100 presented again after completion -> inst_valid_o the next cycle with 0x00100513; mem_rd_o never asserted.
3. mem_gnt_i low for 3 cycles after the 2nd granted read, fetch at 0x200 -> byte 1 still captured; issue resumes at 0x202; inst_valid_o delayed by exactly 3 cycles; correct word.
4. branch_flag_i pulsed while issue_idx=2, fetch at 0x300 -> no inst_valid_o; IDLE next cycle; stallreq_o=0; new pc_i=0x400 starts a fresh fetch, and its result contains no 0x300 bytes.
5. Fetch at 0xFFFFFFFE -> mem_addr_o sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
6. rst asserted low mid-RD -> outputs 0 immediately, without waiting for a clock edge; buffer invalid. After release, a repeat of the previous pc_i goes through RAM rather than the buffer.

Source files
------------

// File: rtl/if_mem_responder_pkg.sv
// ============================================================================
// Module      : if_mem_responder_pkg
// Description : Shared definitions for the instruction-fetch responder:
//               reset level, RAM byte-bus width, FSM encodings and the
//               valid / stall output levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_mem_responder_pkg;

    // Active level of the asynchronous low-true reset input
    localparam logic c_RST_N        = 1'b0;

    // Width of the shared RAM read-data bus
    localparam int   c_BYTE_W       = 8;

    // Output levels for the IF/ID valid strobe and the stall request
    localparam logic c_INST_VALID   = 1'b1;
    localparam logic c_INST_INVALID = 1'b0;
    localparam logic c_STALL_REQ    = 1'b1;
    localparam logic c_NO_STALL_REQ = 1'b0;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_byte_assembler.sv
// ============================================================================
// Module      : if_byte_assembler
// Description : Collects returned RAM bytes into consecutive lanes of an
//               instruction word, lane 0 first (little-endian).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_byte_assembler
    import if_mem_responder_pkg::*;
#(
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [c_BYTE_W-1:0] byte_i,
    output logic [INST_W-1:0]   word_o
);

    localparam int c_LANES = INST_W / c_BYTE_W;
    localparam int c_IDX_W = $clog2(c_LANES);

    logic [c_IDX_W-1:0] rx_idx_q;
    logic [c_LANES-1:0] w_lane_we;

    // Lane pointer: restarts on a new fetch or flush, advances per captured byte
    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_N) begin
            rx_idx_q <= '0;
        end else if (clr_i) begin
            rx_idx_q <= '0;
        end else if (wr_en_i) begin
            rx_idx_q <= rx_idx_q + c_IDX_W'(1);
        end
    end

    generate
        for (genvar l = 0; l < c_LANES; l++) begin : g_lane
            logic [c_BYTE_W-1:0] lane_q;

            assign w_lane_we[l] = wr_en_i && !clr_i && (rx_idx_q == c_IDX_W'(l));

            // Each lane holds the byte captured while the pointer addressed it
            always_ff @(posedge clk or negedge rst) begin
                if (rst == c_RST_N) begin
                    lane_q <= '0;
                end else if (w_lane_we[l]) begin
                    lane_q <= byte_i;
                end
            end

            assign word_o[l*c_BYTE_W +: c_BYTE_W] = lane_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/if_mem_responder.sv
// ============================================================================
// Module      : if_mem_responder
// Description : Instruction-fetch responder. Reads four bytes over the shared
//               byte-wide RAM port, assembles a little-endian instruction,
//               stalls the pipeline while busy and serves a repeated PC from
//               a one-entry last-fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_mem_responder
    import if_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    input  logic                branch_flag_i,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_rd_o,
    input  logic [c_BYTE_W-1:0] mem_din_i,
    output logic [INST_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    output logic                inst_valid_o,
    output logic                stallreq_o
);

    localparam logic [1:0] c_LAST_IDX = 2'd3;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [1:0]        issue_idx_q, issue_idx_d;
    logic              rd_pending_q, rd_pending_d;   // a granted read returns data this cycle
    logic              hit_q, hit_d;                 // buffer hit accepted last cycle
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [INST_W-1:0] buf_data_q, buf_data_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;

    logic              w_hit;
    logic              w_clr;
    logic              w_pulse;
    logic              w_stall;
    logic              w_capture;
    logic [INST_W-1:0] w_word;

    assign w_hit     = buf_valid_q && (pc_i == buf_addr_q);
    // A flush discards the byte arriving in the same cycle
    assign w_capture = rd_pending_q && !branch_flag_i;

    if_byte_assembler #(
        .INST_W (INST_W)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_clr),
        .wr_en_i (w_capture),
        .byte_i  (mem_din_i),
        .word_o  (w_word)
    );

    // Next-state, RAM strobe and output decode; a flush overrides everything
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        issue_idx_d  = issue_idx_q;
        rd_pending_d = 1'b0;
        hit_d        = 1'b0;
        buf_valid_d  = buf_valid_q;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        out_inst_d   = out_inst_q;
        out_addr_d   = out_addr_q;
        w_clr        = 1'b0;
        w_pulse      = c_INST_INVALID;
        w_stall      = c_NO_STALL_REQ;
        mem_rd_o     = 1'b0;
        mem_addr_o   = '0;

        if (branch_flag_i) begin
            state_d     = S_IDLE;
            issue_idx_d = '0;
            w_clr       = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ce_i) begin
                        if (w_hit) begin
                            hit_d      = 1'b1;
                            out_inst_d = buf_data_q;
                            out_addr_d = buf_addr_q;
                        end else begin
                            req_addr_d  = pc_i;
                            issue_idx_d = '0;
                            w_clr       = 1'b1;
                            w_stall     = c_STALL_REQ;
                            state_d     = S_RD;
                        end
                    end
                end
                S_RD: begin
                    w_stall    = c_STALL_REQ;
                    mem_rd_o   = mem_gnt_i;
                    mem_addr_o = req_addr_q + ADDR_W'(issue_idx_q);
                    if (mem_gnt_i) begin
                        rd_pending_d = 1'b1;
                        issue_idx_d  = issue_idx_q + 2'd1;
                        if (issue_idx_q == c_LAST_IDX) begin
                            state_d = S_LAST;
                        end
                    end
                end
                S_LAST: begin
                    w_stall = c_STALL_REQ;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    w_pulse     = c_INST_VALID;
                    out_inst_d  = w_word;
                    out_addr_d  = req_addr_q;
                    buf_valid_d = 1'b1;
                    buf_addr_d  = req_addr_q;
                    buf_data_d  = w_word;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer, buffer and held-output registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_N) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            issue_idx_q  <= '0;
            rd_pending_q <= 1'b0;
            hit_q        <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            out_inst_q   <= '0;
            out_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            issue_idx_q  <= issue_idx_d;
            rd_pending_q <= rd_pending_d;
            hit_q        <= hit_d;
            buf_valid_q  <= buf_valid_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            out_inst_q   <= out_inst_d;
            out_addr_q   <= out_addr_d;
        end
    end

    // In DONE the fresh word bypasses the hold register so it is visible with the pulse
    assign inst_o       = w_pulse ? w_word     : out_inst_q;
    assign inst_addr_o  = w_pulse ? req_addr_q : out_addr_q;
    assign inst_valid_o = w_pulse | (hit_q & ~branch_flag_i);
    // Stall decode depends on ce_i, so it is forced low while reset is held
    assign stallreq_o   = (rst == c_RST_N) ? c_NO_STALL_REQ : w_stall;

endmodule

`default_nettype wire
